// File: rtl/cam_cmd_ctrl_if.sv
// cam_cmd_ctrl_if
// Command and response channels of the CAM command sequencer.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 00 LOOKUP, 01 REPLACE, 10 INIT, 11 reserved
//   cmd_key / cmd_data  : search value / replacement value
//   rsp_valid/rsp_ready : response handshake
//   rsp_hit/max/min/err : match flag, highest/lowest match address, bad-opcode flag
// Modport master: the command source / response sink.
// Modport slave : the sequencer itself.
interface cam_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_key;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [2:0] rsp_max;
    logic [2:0] rsp_min;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_max, rsp_min, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_max, rsp_min, rsp_err
    );
endinterface

// File: rtl/cam_cmd_ctrl.sv
// cam_cmd_ctrl
// Sequencer in front of an 8-entry x 4-bit combinational CAM. Accepts
// LOOKUP / REPLACE / INIT commands, drives the CAM for exactly one cycle,
// captures its result and returns it on a held response channel. Because the
// CAM has no reset, the block pulses cam_init for one cycle after reset.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus (slave modport)   : command and response channels
//   cam_init, cam_setD    : CAM load-all / write-matching strobes
//   cam_lookup, cam_newD  : CAM search key / write data
//   cam_valid/max/min     : CAM match result (combinational from cam_lookup)
//   hit_cnt, miss_cnt     : saturating statistics, only with CAM_CTRL_STATS_EN
// Build option: define CAM_CTRL_STATS_EN to add the statistics counters and
// the CNT_W parameter that sizes them.
module cam_cmd_ctrl
`ifdef CAM_CTRL_STATS_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic              clk,
    input  logic              reset_n,
    cam_cmd_ctrl_if.slave     bus,
    output logic              cam_init,
    output logic              cam_setD,
    output logic [3:0]        cam_lookup,
    output logic [3:0]        cam_newD,
    input  logic              cam_valid,
    input  logic [2:0]        cam_max,
    input  logic [2:0]        cam_min
`ifdef CAM_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);

    localparam logic [1:0] OP_LOOKUP  = 2'b00;
    localparam logic [1:0] OP_REPLACE = 2'b01;
    localparam logic [1:0] OP_INIT    = 2'b10;

    typedef enum logic [1:0] {BOOT, IDLE, EXEC, RESP} state_t;

    state_t     state_reg, state_next;
    logic [1:0] op_reg;
    logic [3:0] key_reg;
    logic [3:0] data_reg;
    logic       hit_reg;
    logic [2:0] max_reg;
    logic [2:0] min_reg;
    logic       err_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        cam_init      = 1'b0;
        cam_setD      = 1'b0;
        cam_lookup    = 4'd0;
        cam_newD      = 4'd0;
        case (state_reg)
            BOOT: begin
                cam_init   = 1'b1;
                state_next = IDLE;
            end
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Reserved opcodes leave every CAM input at zero.
                case (op_reg)
                    OP_LOOKUP: begin
                        cam_lookup = key_reg;
                    end
                    OP_REPLACE: begin
                        cam_lookup = key_reg;
                        cam_newD   = data_reg;
                        cam_setD   = 1'b1;
                    end
                    OP_INIT: begin
                        cam_init = 1'b1;
                    end
                    default: ;
                endcase
                state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Command latch: only loaded on the accepting edge, so EXEC always sees
    // the command that was handshaken even if the source changes afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg   <= 2'b00;
            key_reg  <= 4'd0;
            data_reg <= 4'd0;
        end else if (state_reg == IDLE && bus.cmd_valid) begin
            op_reg   <= bus.cmd_op;
            key_reg  <= bus.cmd_key;
            data_reg <= bus.cmd_data;
        end
    end

    // Result capture at the end of EXEC. The CAM result is sampled before the
    // REPLACE write lands, so it reports the pre-write matches. INIT and
    // reserved opcodes ignore the CAM result entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_reg <= 1'b0;
            max_reg <= 3'd0;
            min_reg <= 3'd0;
            err_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            hit_reg <= 1'b0;
            max_reg <= 3'd0;
            min_reg <= 3'd0;
            err_reg <= 1'b0;
            case (op_reg)
                OP_LOOKUP, OP_REPLACE: begin
                    hit_reg <= cam_valid;
                    max_reg <= cam_valid ? cam_max : 3'd0;
                    min_reg <= cam_valid ? cam_min : 3'd0;
                end
                OP_INIT: ;
                default: err_reg <= 1'b1;
            endcase
        end
    end

    assign bus.rsp_hit = hit_reg;
    assign bus.rsp_max = max_reg;
    assign bus.rsp_min = min_reg;
    assign bus.rsp_err = err_reg;

`ifdef CAM_CTRL_STATS_EN
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [CNT_W-1:0] miss_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (state_reg == EXEC) begin
            if (op_reg == OP_INIT) begin
                hit_cnt_reg  <= '0;
                miss_cnt_reg <= '0;
            end else if (op_reg == OP_LOOKUP || op_reg == OP_REPLACE) begin
                if (cam_valid) begin
                    if (hit_cnt_reg != '1) begin
                        hit_cnt_reg <= hit_cnt_reg + 1'b1;
                    end
                end else if (miss_cnt_reg != '1) begin
                    miss_cnt_reg <= miss_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// tb_cam_cmd_ctrl
// Drives cam_cmd_ctrl with directed and random commands. A behavioural CAM
// sits on the cam_* ports, and a separate command-level reference model
// predicts every response and counter value.
module tb_cam_cmd_ctrl;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cam_init, cam_setD;
    logic [3:0] cam_lookup, cam_newD;
    logic       cam_valid;
    logic [2:0] cam_max, cam_min;
`ifdef CAM_CTRL_STATS_EN
    logic [CW-1:0] hit_cnt, miss_cnt;
`endif

    cam_cmd_ctrl_if bus ();

`ifdef CAM_CTRL_STATS_EN
    cam_cmd_ctrl #(.CNT_W(CW)) dut (
`else
    cam_cmd_ctrl dut (
`endif
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .cam_init   (cam_init),
        .cam_setD   (cam_setD),
        .cam_lookup (cam_lookup),
        .cam_newD   (cam_newD),
        .cam_valid  (cam_valid),
        .cam_max    (cam_max),
        .cam_min    (cam_min)
`ifdef CAM_CTRL_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural CAM attached to the DUT. On a miss it presents non-zero
    // addresses so that the DUT's zeroing of rsp_max/rsp_min is exercised.
    logic [3:0] cam_mem [8];

    always_comb begin
        cam_valid = 1'b0;
        cam_max   = 3'd5;
        cam_min   = 3'd6;
        for (int i = 0; i < 8; i++) begin
            if (cam_mem[i] === cam_lookup) begin
                if (!cam_valid) cam_min = 3'(i);
                cam_max   = 3'(i);
                cam_valid = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (cam_init) cam_mem[i] <= 4'(8 + i);
            else if (cam_setD && cam_mem[i] === cam_lookup) cam_mem[i] <= cam_newD;
        end
    end

    // Command-level reference model.
    int         ref_mem [8];
    int         exp_hit_cnt, exp_miss_cnt;
    logic       exp_hit, exp_err;
    logic [2:0] exp_max, exp_min;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [3:0] key, input logic [3:0] data);
        exp_hit = 1'b0; exp_err = 1'b0; exp_max = 3'd0; exp_min = 3'd0;
        if (op == 2'd0 || op == 2'd1) begin
            for (int i = 0; i < 8; i++) begin
                if (ref_mem[i] == int'(key)) begin
                    if (!exp_hit) exp_min = 3'(i);
                    exp_max = 3'(i);
                    exp_hit = 1'b1;
                end
            end
            if (op == 2'd1) begin
                foreach (ref_mem[i]) if (ref_mem[i] == int'(key)) ref_mem[i] = int'(data);
            end
            if (exp_hit) begin
                if (exp_hit_cnt < MAXC) exp_hit_cnt++;
            end else if (exp_miss_cnt < MAXC) begin
                exp_miss_cnt++;
            end
        end else if (op == 2'd2) begin
            foreach (ref_mem[i]) ref_mem[i] = 8 + i;
            exp_hit_cnt  = 0;
            exp_miss_cnt = 0;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic check_rsp(input string tag);
        check({tag, "_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_hit"},   bus.rsp_hit,   exp_hit);
        check({tag, "_max"},   bus.rsp_max,   exp_max);
        check({tag, "_min"},   bus.rsp_min,   exp_min);
        check({tag, "_err"},   bus.rsp_err,   exp_err);
    endtask

    // Reset, possibly mid-operation; returns once the block is back in IDLE.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_hit",   bus.rsp_hit,   1'b0);
        check("rst_rsp_max",   bus.rsp_max,   3'd0);
        check("rst_rsp_min",   bus.rsp_min,   3'd0);
        check("rst_rsp_err",   bus.rsp_err,   1'b0);
        check("rst_cam_init",  cam_init,      1'b1);
        check("rst_cam_setD",  cam_setD,      1'b0);
        check("rst_cam_lookup", cam_lookup,   4'd0);
        check("rst_cam_newD",  cam_newD,      4'd0);
`ifdef CAM_CTRL_STATS_EN
        check("rst_hit_cnt",  hit_cnt,  '0);
        check("rst_miss_cnt", miss_cnt, '0);
`endif
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = 8 + i;
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
        @(negedge clk);
        check("boot_cam_init",  cam_init,      1'b1);
        check("boot_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        check("idle_cam_init",  cam_init,      1'b0);
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    // Issue one command and stop in RESP with the response checked.
    task automatic send(input logic [1:0] op, input logic [3:0] key, input logic [3:0] data);
        int n;
        model_cmd(op, key, data);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.cmd_data  = data;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_bound", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("exec_rsp_valid", bus.rsp_valid, 1'b0);
        check("exec_cmd_ready", bus.cmd_ready, 1'b0);
        check("exec_cam_init",  cam_init, op == 2'd2);
        check("exec_cam_setD",  cam_setD, op == 2'd1);
        if (op == 2'd0 || op == 2'd1) check("exec_cam_lookup", cam_lookup, key);
        if (op == 2'd1) check("exec_cam_newD", cam_newD, data);
        @(negedge clk);
        check_rsp("rsp");
`ifdef CAM_CTRL_STATS_EN
        check("hit_cnt",  hit_cnt,  exp_hit_cnt);
        check("miss_cnt", miss_cnt, exp_miss_cnt);
`endif
        $display("cmd op=%0d key=%h data=%h -> hit=%0d max=%0d min=%0d err=%0d",
                 op, key, data, bus.rsp_hit, bus.rsp_max, bus.rsp_min, bus.rsp_err);
    endtask

    // Hold the response for 'hold' cycles (optionally pulsing a stray command),
    // then complete the handshake and confirm the return to IDLE.
    task automatic finish_rsp(input int hold, input bit pulse);
        for (int c = 0; c < hold; c++) begin
            bus.cmd_valid = pulse && (c == 0);
            bus.cmd_op    = 2'd2;
            @(negedge clk);
            check("hold_cmd_ready", bus.cmd_ready, 1'b0);
            check_rsp("hold");
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("done_rsp_valid", bus.rsp_valid, 1'b0);
        check("done_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        logic [3:0] k;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_key   = 4'd0;
        bus.cmd_data  = 4'd0;
        bus.rsp_ready = 1'b0;
        exp_hit_cnt   = 0;
        exp_miss_cnt  = 0;
        #2;
        do_reset();

        send(2'd0, 4'hA, 4'h0); finish_rsp(0, 1'b0);   // hit at 2
        send(2'd0, 4'h0, 4'h0); finish_rsp(1, 1'b0);   // miss
        send(2'd1, 4'hA, 4'h3); finish_rsp(0, 1'b0);   // replace A->3
        send(2'd0, 4'h3, 4'h0); finish_rsp(0, 1'b0);
        send(2'd0, 4'hA, 4'h0); finish_rsp(0, 1'b0);
        send(2'd1, 4'h9, 4'hB); finish_rsp(0, 1'b0);   // B now at 1 and 3
        send(2'd0, 4'hB, 4'h0); finish_rsp(0, 1'b0);
        send(2'd1, 4'h5, 4'h5); finish_rsp(0, 1'b0);   // miss, nothing written
        send(2'd1, 4'hC, 4'hC); finish_rsp(0, 1'b0);   // data equal to key

        send(2'd0, 4'hB, 4'h0); finish_rsp(5, 1'b1);   // held response, stray cmd

        send(2'd0, 4'hB, 4'h0); do_reset();            // reset mid-RESP
        send(2'd0, 4'hB, 4'h0); finish_rsp(0, 1'b0);   // only entry 3 after re-init
        send(2'd3, 4'h5, 4'h7); finish_rsp(0, 1'b0);   // reserved opcode
        send(2'd0, 4'hB, 4'h0); finish_rsp(0, 1'b0);
        send(2'd0, 4'h0, 4'h0); finish_rsp(0, 1'b0);
`ifdef CAM_CTRL_STATS_EN
        check("stats_hits_2",  hit_cnt,  3'd2);
        check("stats_miss_1",  miss_cnt, 3'd1);
`endif
        send(2'd2, 4'h0, 4'h0); finish_rsp(0, 1'b0);   // INIT
`ifdef CAM_CTRL_STATS_EN
        check("stats_init_hits", hit_cnt,  3'd0);
        check("stats_init_miss", miss_cnt, 3'd0);
`endif

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 2) != 0) k = 4'(ref_mem[$urandom_range(0, 7)]);
            else k = 4'($urandom);
            send(2'($urandom_range(0, 3)), k, 4'($urandom));
            finish_rsp(int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cam_cmd_ctrl.md
# cam_cmd_ctrl

Command sequencer that sits directly upstream of the 8-entry × 4-bit CAM and drives its `init`, `setD`, `D_lookup` and `newD` inputs. It accepts LOOKUP, REPLACE and INIT commands over a valid/ready handshake and runs each command against the CAM for exactly one cycle. It captures the CAM's `valid`, `max_addr` and `min_addr` results and returns them over a valid/ready response channel. The CAM has no reset, so this block also performs the CAM's initial load automatically after reset.

## Interface
Parameters:
- CNT_W, default 8: width of the statistics counters. Used only when the statistics feature is compiled in.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  2  command opcode: 00 LOOKUP, 01 REPLACE, 10 INIT, 11 reserved
- cmd_key  in  4  value to search for
- cmd_data  in  4  replacement value, used by REPLACE only
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts the response
- rsp_hit  out  1  at least one CAM entry matched
- rsp_max  out  3  highest matching address; 0 on a miss
- rsp_min  out  3  lowest matching address; 0 on a miss
- rsp_err  out  1  command used the reserved opcode
- cam_init  out  1  drives the CAM's `init` input
- cam_setD  out  1  drives the CAM's `setD` input
- cam_lookup  out  4  drives the CAM's `D_lookup` input
- cam_newD  out  4  drives the CAM's `newD` input
- cam_valid  in  1  CAM `valid` output
- cam_max  in  3  CAM `max_addr` output
- cam_min  in  3  CAM `min_addr` output
- hit_cnt  out  CNT_W  number of hits; present only when the statistics feature is compiled in
- miss_cnt  out  CNT_W  number of misses; present only when the statistics feature is compiled in

## Operation
State machine states: BOOT, IDLE, EXEC, RESP.

- **BOOT**
  - Entered on reset. Lasts exactly one cycle after reset_n deasserts.
  - Drives cam_init=1, which loads CAM entry i with 8+i.
  - Next state: IDLE. No response is produced.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch cmd_op, cmd_key and cmd_data, then go to EXEC.
- **EXEC** (one cycle) drives the CAM from the latched command:
  - LOOKUP: cam_lookup=key.
  - REPLACE: cam_lookup=key, cam_newD=data, cam_setD=1. Every matching entry is written at the closing edge. The response reports the matches as they were before the write.
  - INIT: cam_init=1. Response is hit=0, max=0, min=0.
  - Reserved opcode: the CAM is not touched (cam_setD=0, cam_init=0). Response is rsp_err=1, hit=0.
  - At the closing edge, register rsp_hit=cam_valid. Register rsp_max and rsp_min from cam_max and cam_min when cam_valid=1, otherwise 0. Go to RESP.
- **RESP**
  - rsp_valid=1. All rsp_* outputs hold stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge, go to IDLE.

CAM drive outside EXEC and BOOT: cam_init=0, cam_setD=0, cam_lookup=0, cam_newD=0.

Boundary conditions:
- REPLACE that misses: no entry is written; rsp_hit=0.
- REPLACE with data equal to key: the write still occurs and the response is a normal hit.
- cmd_valid while not in IDLE: ignored; the command must be held until cmd_ready=1.
- Reset asserted mid-operation: all outputs go to their reset values immediately, and a command that has not finished is lost. BOOT re-initialises the CAM after reset deasserts.

## Timing
- Reset values:
  - state=BOOT.
  - cmd_ready=0, rsp_valid=0, rsp_hit=0, rsp_max=0, rsp_min=0, rsp_err=0.
  - cam_init=1 (BOOT), cam_setD=0, cam_lookup=0, cam_newD=0.
  - hit_cnt=0, miss_cnt=0.
- Handshake to response: command accepted at edge k; EXEC occupies cycle k+1; rsp_valid is high from cycle k+2.
- Throughput: at most one command every 3 cycles when rsp_ready is held high.
- The CAM is combinational from input to result. Its results are sampled in the same cycle the lookup is driven.

## Configuration
- `CAM_CTRL_STATS_EN` defined:
  - hit_cnt and miss_cnt ports exist.
  - At the end of each LOOKUP or REPLACE, increment hit_cnt on a hit or miss_cnt on a miss.
  - Both counters saturate at all ones.
  - An INIT command clears both counters.
  - Reserved opcodes count nothing.
- `CAM_CTRL_STATS_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset, then LOOKUP key A -> cam_init=1 for exactly one cycle after reset; response hit=1, max=2, min=2, err=0.
- LOOKUP key 0 after boot -> hit=0, max=0, min=0.
- REPLACE key A data 3 -> hit=1, max=2, min=2. Then LOOKUP 3 -> hit=1, max=2, min=2. Then LOOKUP A -> hit=0.
- REPLACE key 9 data B -> hit=1, max=1, min=1. Then LOOKUP B -> hit=1, max=3, min=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> response outputs stable throughout; cmd_ready=0 throughout; a cmd_valid pulse is ignored. Pulse reset_n mid-RESP -> rsp_valid drops immediately; BOOT re-inits the CAM, so LOOKUP B then gives hit=1, max=3, min=3.
- Reserved opcode 11 -> err=1, hit=0, and CAM contents unchanged. With `CAM_CTRL_STATS_EN` defined: 2 hits and 1 miss give hit_cnt=2, miss_cnt=1; a following INIT gives hit_cnt=0, miss_cnt=0.
